// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard controller: conditions the raw PS/2 lines, validates 11-bit
// frames, folds scan-code set 2 prefixes into key events and buffers them
// in a 4-entry first-word-fall-through FIFO behind a valid/ready port.
module ps2_key_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned FILT_LEN       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       evt_valid,
    output logic [9:0] evt_data,
    input  logic       evt_ready,
    output logic       err_parity,
    output logic       err_frame,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       busy
);

    localparam int unsigned FCNT_W   = $clog2(FILT_LEN + 1);
    localparam int unsigned WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FRAME_W  = 11;
    localparam int unsigned BCNT_W   = 4;
    localparam int unsigned EVT_W    = 10;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned PTR_W    = 2;
    localparam int unsigned CNT_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: index 0 = PS/2 clock, index 1 = PS/2 data
    // ------------------------------------------------------------------
    logic [1:0]        sync1;
    logic [1:0]        sync2;
    logic [1:0]        filt;
    logic [FCNT_W-1:0] fcnt [2];
    logic              filt_clk_d;
    logic              fall_c;

    // Two-flop synchronizer followed by a run-length glitch filter per line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
            filt  <= 2'b11;
            for (int i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            sync1 <= {ps2_data_i, ps2_clk_i};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FCNT_W'(FILT_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FCNT_W'(1);
                end
            end
        end
    end

    // Delayed filtered clock for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) filt_clk_d <= 1'b1;
        else     filt_clk_d <= filt[0];
    end

    assign fall_c = filt_clk_d & ~filt[0];

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t              state;
    state_t              state_nxt;
    logic [FRAME_W-1:0]  sr;
    logic [BCNT_W-1:0]   bit_cnt;
    logic [WD_W-1:0]     wd;
    logic                err_par_nxt;
    logic                err_frm_nxt;
    logic                byte_vld_nxt;
    logic                byte_valid;
    logic [7:0]          rx_byte;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and frame verdict; sr = {stop, parity, data[7:0], start}
    always_comb begin
        state_nxt    = state;
        err_par_nxt  = 1'b0;
        err_frm_nxt  = 1'b0;
        byte_vld_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (fall_c) state_nxt = RECV;
            end
            RECV: begin
                if (fall_c) begin
                    if (bit_cnt == BCNT_W'(FRAME_W - 1)) state_nxt = CHECK;
                end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    err_frm_nxt = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
                if (sr[0] || !sr[FRAME_W-1]) begin
                    err_frm_nxt = 1'b1;
                end else if (!(^sr[9:1])) begin
                    err_par_nxt = 1'b1;
                end else begin
                    byte_vld_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register, bit counter and inter-bit watchdog
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            bit_cnt <= '0;
            wd      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wd <= '0;
                    if (fall_c) begin
                        sr      <= {filt[1], sr[FRAME_W-1:1]};
                        bit_cnt <= BCNT_W'(1);
                    end
                end
                RECV: begin
                    if (fall_c) begin
                        sr      <= {filt[1], sr[FRAME_W-1:1]};
                        bit_cnt <= bit_cnt + BCNT_W'(1);
                        wd      <= '0;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                default: wd <= '0;
            endcase
        end
    end

    // Registered frame results and busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            busy       <= 1'b0;
        end else begin
            err_parity <= err_par_nxt;
            err_frame  <= err_frm_nxt;
            byte_valid <= byte_vld_nxt;
            busy       <= (state_nxt != IDLE);
            if (state == CHECK) rx_byte <= sr[8:1];
        end
    end

    // ------------------------------------------------------------------
    // Scan-code decode
    // ------------------------------------------------------------------
    logic             ext;
    logic             brk;
    logic             push_c;
    logic [EVT_W-1:0] push_data_c;
    logic             is_prefix_c;
    logic             is_resp_c;

    // Classify the received byte
    always_comb begin
        is_prefix_c = (rx_byte == 8'hE0) || (rx_byte == 8'hF0);
        is_resp_c   = 1'b0;
        case (rx_byte)
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_resp_c = 1'b1;
            default:                                 is_resp_c = 1'b0;
        endcase
        push_c      = byte_valid && !is_prefix_c && !is_resp_c;
        push_data_c = {brk, ext, rx_byte};
    end

    // Prefix flags: set by E0/F0, cleared by any other byte or frame error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (err_parity || err_frame) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (byte_valid) begin
            if (rx_byte == 8'hE0) begin
                ext <= 1'b1;
            end else if (rx_byte == 8'hF0) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [EVT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop_c;
    logic             push_ok_c;
    logic [PTR_W-1:0] rd_nxt_c;
    logic [CNT_W-1:0] count_nxt_c;
    logic [EVT_W-1:0] head_nxt_c;

    // Handshake, occupancy and next head selection
    always_comb begin
        pop_c       = (count != '0) && evt_ready;
        push_ok_c   = push_c && ((count != CNT_W'(DEPTH)) || pop_c);
        rd_nxt_c    = rd_ptr + PTR_W'(pop_c);
        count_nxt_c = count + CNT_W'(push_ok_c) - CNT_W'(pop_c);
        if (push_ok_c && ((count - CNT_W'(pop_c)) == '0)) head_nxt_c = push_data_c;
        else                                              head_nxt_c = mem[rd_nxt_c];
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok_c) mem[wr_ptr] <= push_data_c;
    end

    // Pointers, count, registered head and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            evt_valid <= 1'b0;
            evt_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr    <= rd_nxt_c;
            count     <= count_nxt_c;
            evt_valid <= (count_nxt_c != '0);
            evt_data  <= head_nxt_c;
            if (push_c && !push_ok_c) overflow <= 1'b1;
            else if (ovf_clr)         overflow <= 1'b0;
        end
    end

endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

PS/2 keyboard controller that samples the raw PS/2 clock/data lines and validates each 11-bit frame (start, parity, stop, inter-bit timeout). It folds the scan-code set 2 prefixes (E0 extended, F0 break) into single key events and buffers them in a 4-entry FIFO. The CPU-side MMIO reader consumes events through a valid/ready handshake. It replaces the free-running two-byte snapshot with discrete, error-checked key events.

## Interface
- TIMEOUT_CYCLES, 10000, clk cycles allowed between PS/2 clock falling edges inside a frame (100 µs at 100 MHz)
- FILT_LEN, 4, consecutive equal samples required to change a filtered line
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ps2_clk_i  in  1  raw PS/2 clock pin, asynchronous
- ps2_data_i  in  1  raw PS/2 data pin, asynchronous
- evt_valid  out  1  FIFO head holds an event
- evt_data  out  10  {break, extended, code[7:0]} of FIFO head
- evt_ready  in  1  consumer accepts head when evt_valid & evt_ready
- err_parity  out  1  one-cycle pulse on a frame with bad parity
- err_frame  out  1  one-cycle pulse on bad start/stop bit or timeout
- overflow  out  1  sticky, set when an event is dropped because the FIFO is full
- ovf_clr  in  1  clears overflow (set wins if both occur in the same cycle)
- busy  out  1  high while the frame FSM is not in IDLE

## Operation
- Input conditioning:
  - Both pins pass through a 2-flop synchronizer, then a FILT_LEN glitch filter.
  - The filtered line flips only after FILT_LEN identical samples.
  - fall_pulse = one-cycle pulse on a filtered clock 1→0 transition.
- Frame FSM, states IDLE, RECV, CHECK:
  - IDLE: on fall_pulse, sample data as bit 0, bit count = 1, go to RECV.
  - RECV: on each fall_pulse, shift data in LSB-first and increment the count. When count reaches 11, go to CHECK.
  - RECV timeout: a watchdog counter resets on every fall_pulse. If it reaches TIMEOUT_CYCLES, pulse err_frame, discard the frame and go to IDLE.
  - CHECK, one cycle: require start=0, stop=1 and odd parity over data+parity.
    - Start or stop wrong: err_frame pulse.
    - Otherwise parity wrong: err_parity pulse.
    - Otherwise: byte_valid pulse with the byte.
    - In all cases return to IDLE.
- Decode (flags ext, brk; both 0 at reset):
  - Byte 0xE0: ext ← 1.
  - Byte 0xF0: brk ← 1.
  - Bytes 0xFA, 0xAA, 0xEE, 0xFE, 0x00, 0xFF (device responses): dropped, both flags cleared.
  - Any other byte: push {brk, ext, byte}, clear both flags.
  - Any err_parity/err_frame also clears both flags.
- FIFO:
  - Depth 4, first-word fall-through; evt_data = head entry.
  - A push is accepted if not full, or if a pop happens in the same cycle.
  - A rejected push sets overflow; the event is lost and FIFO contents are unchanged.
  - Pop = evt_valid & evt_ready. evt_ready while empty has no effect.
  - Pointers are 2-bit wrap-around plus a 3-bit count (0–4).

## Timing
- Reset values:
  - evt_valid=0, evt_data=0, err_parity=0, err_frame=0, overflow=0, busy=0.
  - FSM in IDLE, flags clear, FIFO empty, watchdog 0.
- Reset asserted mid-frame aborts the frame and empties the FIFO. The next fall_pulse after release is treated as a start bit.
- Latency:
  - Raw pin change to filtered change: 2 + FILT_LEN cycles.
  - Stop-bit fall_pulse at cycle T → CHECK at T+1 → decode/push at T+2 → evt_valid=1 at T+3 (if the FIFO was empty).
  - err pulses are asserted during cycle T+2.
- evt_data is stable while evt_valid=1 and no pop occurs. After a pop, the next entry appears the following cycle.
- busy rises the cycle after the start-bit fall_pulse and falls the cycle after CHECK or timeout.
- A fall_pulse arriving during CHECK is ignored; devices guarantee ≥30 µs between frames.

## Test plan
- Frame 0x1C (start 0, data LSB-first, parity 0, stop 1) → evt_valid at T+3 with evt_data=0x01C; evt_ready=1 → evt_valid=0 next cycle.
- Sequence E0, F0, 75 → exactly one event, evt_data=0x375; flags clear afterwards, confirmed by a following 0x1C giving 0x01C.
- Frame 0x1C with parity bit 1 → err_parity pulse for 1 cycle, no event; then E0 followed by a stop-bit-0 frame → err_frame pulse and ext cleared.
- Send 5 clock edges, then hold clock high for TIMEOUT_CYCLES → err_frame pulse, busy=0; a following valid frame 0x29 → evt_data=0x029.
- evt_ready=0, send codes 0x15, 0x1D, 0x24, 0x2D, 0x2C:
  - First four are buffered; overflow=1 after the fifth.
  - Reads return 0x015, 0x01D, 0x024, 0x02D.
  - ovf_clr → overflow=0.
- FIFO full with evt_ready=1 held in the same cycle as a push → push accepted, count stays 4, overflow stays 0; assert rst mid-frame → all outputs at reset values.
